// File: rtl/serial_tx_scheduler_pkg.sv
// serial_tx_scheduler_pkg: state encoding, default sizes and width helper for the scheduler
package serial_tx_scheduler_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_GAP = 2'd2} state_t;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_GAP = 2;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or above ptr
module rr_arbiter
  import serial_tx_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx
);
  logic [ID_W-1:0] j;
  // scan downward so the closest requester to ptr is written last and wins
  always_comb begin
    idx = '0;
    gnt = '0;
    j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = ID_W'((int'(ptr) + k) % N_REQ);
      if (req[j]) idx = j;
    end
    gnt[idx] = |req;
  end
endmodule

// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler: round-robin grant of N_REQ parallel words onto one MSB-first serial line
module serial_tx_scheduler
  import serial_tx_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GAP = DEFAULT_GAP,
  localparam int ID_W = clog2(N_REQ)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [N_REQ-1:0]       REQ_VALID,
  input  logic [N_REQ*WIDTH-1:0] REQ_DATA,
  output logic [N_REQ-1:0]       REQ_READY,
  output logic [ID_W-1:0]        GRANT_ID,
  output logic                   S_OUT,
  output logic                   S_VALID,
  output logic                   S_SYNC,
  output logic                   DONE,
  output logic                   BUSY
);
  localparam int BIT_W = clog2(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] shreg;
  logic [BIT_W-1:0] bit_cnt;
  logic [3:0] gap_cnt;
  logic [ID_W-1:0] rr_ptr, win;
  logic [N_REQ-1:0] gnt;
  logic accept;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(REQ_VALID),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(win)
  );
  assign REQ_READY = state == ST_IDLE ? gnt : '0;
  assign accept = |(REQ_VALID & REQ_READY);
  assign S_VALID = state == ST_SHIFT;
  assign S_OUT = S_VALID & shreg[WIDTH-1];
  assign S_SYNC = S_VALID && bit_cnt == BIT_W'(WIDTH - 1);
  assign DONE = S_VALID && bit_cnt == '0;
  assign BUSY = state != ST_IDLE;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == ST_IDLE && accept) state_n = ST_SHIFT;
    else if (state == ST_SHIFT && bit_cnt == '0) state_n = ST_GAP;
    else if (state == ST_GAP && gap_cnt == '0) state_n = ST_IDLE;
  end
  // counters wrap harmlessly after their terminal value; state leaves before reuse
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shreg <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      rr_ptr <= '0;
      GRANT_ID <= '0;
    end else if (accept) begin
      shreg <= REQ_DATA[win*WIDTH +: WIDTH];
      GRANT_ID <= win;
      bit_cnt <= BIT_W'(WIDTH - 1);
      rr_ptr <= win == ID_W'(N_REQ - 1) ? '0 : win + ID_W'(1);
    end else if (state == ST_SHIFT) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      bit_cnt <= bit_cnt - BIT_W'(1);
      if (bit_cnt == '0) gap_cnt <= 4'(GAP - 1);
    end else if (state == ST_GAP) begin
      gap_cnt <= gap_cnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb_serial_tx_scheduler: directed and randomized checks against a frame-queue reference model
module tb_serial_tx_scheduler;
  localparam int N = 4, W = 32, G = 2;
  logic CLK = 0, RESET = 1;
  logic [N-1:0] REQ_VALID = '0, REQ_READY;
  logic [N*W-1:0] REQ_DATA = '0;
  logic [1:0] GRANT_ID;
  logic S_OUT, S_VALID, S_SYNC, DONE, BUSY;
  int total = 0, bad = 0, cyc = 0;
  typedef struct packed {logic v; logic o; logic sy; logic dn;} ent_t;
  ent_t q[$];
  int m_ptr = 0, m_id = 0;

  always #5 CLK = ~CLK;

  serial_tx_scheduler #(.N_REQ(N), .WIDTH(W), .GAP(G)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .GRANT_ID(GRANT_ID), .S_OUT(S_OUT), .S_VALID(S_VALID),
    .S_SYNC(S_SYNC), .DONE(DONE), .BUSY(BUSY)
  );

  function automatic int winner(logic [N-1:0] v, int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (v[j[1:0]]) return j;
    end
    return -1;
  endfunction

  // model: each acceptance queues the per-cycle expectations for its whole frame plus gap
  task automatic tick();
    int w;
    logic [W-1:0] word;
    @(posedge CLK);
    cyc++;
    if (RESET) begin
      q.delete();
      m_ptr = 0;
      m_id = 0;
    end else if (q.size() > 0) begin
      void'(q.pop_front());
    end else begin
      w = winner(REQ_VALID, m_ptr);
      if (w >= 0) begin
        word = REQ_DATA[w*W +: W];
        for (int i = 0; i < W; i++) q.push_back('{v: 1'b1, o: word[W-1-i], sy: i == 0, dn: i == W - 1});
        repeat (G) q.push_back('{v: 1'b0, o: 1'b0, sy: 1'b0, dn: 1'b0});
        m_id = w;
        m_ptr = (w + 1) % N;
      end
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1;
    REQ_VALID = '0;
    tick();
    tick();
    RESET = 0;
  endtask

  task automatic drain();
    REQ_VALID = '0;
    repeat (W + G + 2) tick();
  endtask

  task automatic test_reset();
    RESET = 1;
    REQ_VALID = '0;
    tick();
    tick();
    total++;
    if ({S_OUT, S_VALID, S_SYNC, DONE, BUSY} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outs: got %b want 00000", {S_OUT, S_VALID, S_SYNC, DONE, BUSY});
    end
    total++;
    if (REQ_READY !== 4'b0 || GRANT_ID !== 2'd0) begin
      bad++;
      $display("FAIL reset_ready_id: got ready=%b id=%0d want 0000/0", REQ_READY, GRANT_ID);
    end
    RESET = 0;
  endtask

  task automatic test_single();
    logic [W-1:0] word = 32'hA500_0001;
    REQ_DATA[2*W +: W] = word;
    REQ_VALID = 4'b0100;
    #1;
    total++;
    if (REQ_READY !== 4'b0100) begin
      bad++;
      $display("FAIL single_ready: got %b want 0100", REQ_READY);
    end
    tick();
    REQ_VALID = '0;
    for (int i = 0; i < W; i++) begin
      total++;
      if ({S_VALID, S_OUT, S_SYNC, DONE} !== {1'b1, word[W-1-i], i == 0, i == W - 1} || GRANT_ID !== 2'd2) begin
        bad++;
        $display("FAIL single_bit%0d: got v/o/sy/dn=%b id=%0d want %b id=2", i,
                 {S_VALID, S_OUT, S_SYNC, DONE}, GRANT_ID, {1'b1, word[W-1-i], i == 0, i == W - 1});
      end
      tick();
    end
    for (int i = 0; i < G; i++) begin
      total++;
      if ({S_VALID, S_OUT, BUSY} !== 3'b001 || REQ_READY !== 4'b0) begin
        bad++;
        $display("FAIL single_gap%0d: got v/o/busy=%b ready=%b want 001/0000", i, {S_VALID, S_OUT, BUSY}, REQ_READY);
      end
      tick();
    end
    total++;
    if (BUSY !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: got busy=%b want 0", BUSY);
    end
  endtask

  task automatic test_reset_midframe();
    int dn = 0;
    do_reset();
    REQ_DATA[0 +: W] = 32'hFFFF_FFFF;
    REQ_VALID = 4'b0001;
    tick();
    REQ_VALID = '0;
    repeat (10) tick();
    total++;
    if (S_VALID !== 1'b1) begin
      bad++;
      $display("FAIL midframe_active: got s_valid=%b want 1", S_VALID);
    end
    RESET = 1;
    #1;
    total++;
    if ({S_VALID, S_OUT, BUSY, DONE} !== 4'b0) begin
      bad++;
      $display("FAIL midframe_async: got v/o/busy/dn=%b want 0000", {S_VALID, S_OUT, BUSY, DONE});
    end
    repeat (2) begin
      dn |= int'(DONE);
      tick();
    end
    RESET = 0;
    repeat (W) begin
      dn |= int'(DONE);
      tick();
    end
    total++;
    if (dn != 0) begin
      bad++;
      $display("FAIL midframe_done: got done pulse=%0d want 0", dn);
    end
    REQ_VALID = 4'b1001;
    #1;
    total++;
    if (REQ_READY !== 4'b0001) begin
      bad++;
      $display("FAIL midframe_ptr: got ready=%b want 0001", REQ_READY);
    end
    tick();
    total++;
    if (GRANT_ID !== 2'd0 || S_SYNC !== 1'b1) begin
      bad++;
      $display("FAIL midframe_grant: got id=%0d sync=%b want 0/1", GRANT_ID, S_SYNC);
    end
    drain();
  endtask

  task automatic test_fairness();
    int ids[$], cycs[$];
    do_reset();
    for (int i = 0; i < N; i++) REQ_DATA[i*W +: W] = W'(i);
    REQ_VALID = '1;
    for (int c = 0; c < 300 && ids.size() < 5; c++) begin
      if (S_SYNC) begin
        ids.push_back(int'(GRANT_ID));
        cycs.push_back(cyc);
      end
      tick();
    end
    total++;
    if (ids.size() != 5) begin
      bad++;
      $display("FAIL fair_timeout: got %0d frames want 5", ids.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (ids[k] != k % N) begin
          bad++;
          $display("FAIL fair_order%0d: got id=%0d want %0d", k, ids[k], k % N);
        end
        if (k > 0) begin
          total++;
          if (cycs[k] - cycs[k-1] != W + G + 1) begin
            bad++;
            $display("FAIL fair_period%0d: got %0d want %0d", k, cycs[k] - cycs[k-1], W + G + 1);
          end
        end
      end
    end
    drain();
  endtask

  task automatic test_data_change();
    do_reset();
    REQ_DATA[0 +: W] = 32'hFFFF_FFFF;
    REQ_VALID = 4'b0001;
    tick();
    REQ_DATA[0 +: W] = '0;
    REQ_VALID = '0;
    for (int i = 0; i < W; i++) begin
      total++;
      if ({S_VALID, S_OUT} !== 2'b11) begin
        bad++;
        $display("FAIL hold_bit%0d: got v/o=%b want 11", i, {S_VALID, S_OUT});
      end
      tick();
    end
    drain();
  endtask

  task automatic test_late_valid();
    int ids[$];
    bit in_gap = 0;
    do_reset();
    REQ_VALID = 4'b0010;
    tick();
    REQ_VALID = 4'b1000;
    for (int c = 0; c < 60 && !in_gap; c++) begin
      if (BUSY && !S_VALID) in_gap = 1;
      else tick();
    end
    total++;
    if (!in_gap) begin
      bad++;
      $display("FAIL late_gap_timeout: got no gap want gap within 60 cycles");
    end
    REQ_VALID = 4'b1010;
    for (int c = 0; c < 150 && ids.size() < 2; c++) begin
      if (S_SYNC) ids.push_back(int'(GRANT_ID));
      tick();
    end
    total++;
    if (ids.size() != 2 || ids[0] != 3 || ids[1] != 1) begin
      bad++;
      $display("FAIL late_order: got %0d frames first=%0d second=%0d want 3 then 1",
               ids.size(), ids.size() > 0 ? ids[0] : -1, ids.size() > 1 ? ids[1] : -1);
    end
    drain();
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      total++;
      if (REQ_READY !== 4'b0 || {BUSY, S_OUT} !== 2'b0) begin
        bad++;
        $display("FAIL idle%0d: got ready=%b busy/o=%b want 0000/00", i, REQ_READY, {BUSY, S_OUT});
      end
      tick();
    end
  endtask

  task automatic test_random();
    ent_t e;
    logic [N-1:0] er;
    int w;
    do_reset();
    for (int i = 0; i < 900; i++) begin
      REQ_VALID = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      REQ_DATA = {$urandom, $urandom, $urandom, $urandom};
      #1;
      e = q.size() > 0 ? q[0] : '0;
      w = winner(REQ_VALID, m_ptr);
      er = '0;
      if (q.size() == 0 && w >= 0) er = 4'(1 << w);
      total++;
      if ({S_VALID, S_OUT, S_SYNC, DONE} !== e || BUSY !== (q.size() > 0) || REQ_READY !== er || GRANT_ID !== 2'(m_id)) begin
        bad++;
        $display("FAIL rand%0d: got v/o/sy/dn=%b busy=%b ready=%b id=%0d want %b busy=%b ready=%b id=%0d", i,
                 {S_VALID, S_OUT, S_SYNC, DONE}, BUSY, REQ_READY, GRANT_ID, e, q.size() > 0, er, m_id);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_midframe();
    test_fairness();
    test_data_change();
    test_late_valid();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
